// File: rtl/seg_pkg.sv
// seg_pkg
//   Shared constants for the 7-segment scan controller: blank patterns,
//   the active-low hex glyph table and the scan FSM state encoding.
//   Segment bit order is {g,f,e,d,c,b,a}; a 0 lights the segment.
package seg_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [3:0] AN_OFF    = 4'hF;

   // Entry n is the glyph for nibble n (entry 15 listed first).
   // b and d are lower-case so they stay distinct from 8 and 0.
   localparam logic [15:0][6:0] HEX_GLYPH = {
      7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
      7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
      7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
      7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
   };

   typedef enum logic {
      BLANK = 1'b0,
      SHOW  = 1'b1
   } state_t;

   // Active-low anode pattern selecting digit i.
   function automatic logic [3:0] digit_an(input logic [1:0] i);
      return ~(4'b0001 << i);
   endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// seg_hex_decode
//   Combinational nibble to active-low 7-segment glyph.
//   Ports:
//     nib    in   4  hex digit
//     glyph  out  7  {g,f,e,d,c,b,a}, active-low
module seg_hex_decode
   import seg_pkg::*;
(
   input  logic [3:0] nib,
   output logic [6:0] glyph
);

   assign glyph = HEX_GLYPH[nib];

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
//   Time-multiplexed scan controller for a 4-digit common-anode 7-segment
//   display. Each digit slot is DIV cycles: BLANK_CYC cycles with all anodes
//   off, then the digit is shown. New values arrive through a valid/ready
//   port into a one-deep pending register and are committed only at the
//   frame boundary, so a frame never mixes old and new digits.
//   Ports:
//     clk         in   1   system clock
//     rst_n       in   1   asynchronous active-low reset
//     wr_valid    in   1   new display value offered
//     wr_data     in   16  four nibbles, [3:0] = digit 0 (rightmost)
//     wr_ready    out  1   pending register empty
//     dp_en       in   4   per-digit decimal point enable (sampled at slot start)
//     an          out  4   anode enables, active-low
//     seg         out  7   segments {g,f,e,d,c,b,a}, active-low
//     dp          out  1   decimal point, active-low
//     frame_done  out  1   one-cycle pulse at the end of the digit-3 slot
//   Build option:
//     LZ_BLANK_EN  blank leading-zero digits 3..1 (digit 0 always lit)
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   BLANK | anodes off, waiting for cnt == BLANK_CYC-1 to light digit idx
//   SHOW  | digit idx displayed until cnt == DIV-1, then next slot
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int DIV       = 26244,
   parameter int BLANK_CYC = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wr_valid,
   input  logic [15:0] wr_data,
   output logic        wr_ready,
   input  logic [3:0]  dp_en,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        frame_done
);

   localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_SHOW = CNT_W'(BLANK_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       idx;
   logic [15:0]      active;
   logic [15:0]      pending;
   logic             pend_full;

   logic             slot_start;
   logic             slot_end;
   logic             frame_end;
   logic [3:0]       nib;
   logic [6:0]       glyph;

   logic [3:0]       an_nxt;
   logic [6:0]       seg_nxt;
   logic             dp_nxt;
   logic             frame_done_nxt;

   assign slot_start = (state == BLANK) && (cnt == CNT_SHOW);
   assign slot_end   = (state == SHOW)  && (cnt == CNT_LAST);
   assign frame_end  = slot_end && (idx == 2'd3);

   assign nib = active[{idx, 2'b00} +: 4];

   seg_hex_decode u_dec (
      .nib   (nib),
      .glyph (glyph)
   );

`ifdef LZ_BLANK_EN
   // Digit idx is a leading zero when it and every higher nibble are zero.
   logic lz;
   assign lz = (idx != 2'd0) && ((active >> {idx, 2'b00}) == 16'h0000);
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= BLANK;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         BLANK: if (cnt == CNT_SHOW) state_nxt = SHOW;
         SHOW:  if (cnt == CNT_LAST) state_nxt = BLANK;
         default: state_nxt = BLANK;
      endcase
   end

   // Output logic: next values for the registered display outputs
   always_comb begin
      an_nxt         = an;
      seg_nxt        = seg;
      dp_nxt         = dp;
      frame_done_nxt = 1'b0;
      if (slot_start) begin
         an_nxt  = digit_an(idx);
         seg_nxt = glyph;
         dp_nxt  = ~dp_en[idx];
`ifdef LZ_BLANK_EN
         if (lz) begin
            seg_nxt = SEG_BLANK;
            // Anode stays on only to light a requested decimal point.
            if (!dp_en[idx]) an_nxt = AN_OFF;
         end
`endif
      end else if (slot_end) begin
         an_nxt         = AN_OFF;
         seg_nxt        = SEG_BLANK;
         dp_nxt         = 1'b1;
         frame_done_nxt = (idx == 2'd3);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an         <= AN_OFF;
         seg        <= SEG_BLANK;
         dp         <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         an         <= an_nxt;
         seg        <= seg_nxt;
         dp         <= dp_nxt;
         frame_done <= frame_done_nxt;
      end
   end

   // Slot counter and digit index
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         idx <= 2'd0;
      end else if (slot_end) begin
         cnt <= '0;
         idx <= idx + 2'd1;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // Pending/active registers. Commit needs a full pending register and
   // accept needs an empty one, so the two branches never compete.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active    <= 16'h0000;
         pending   <= 16'h0000;
         pend_full <= 1'b0;
      end else if (frame_end && pend_full) begin
         active    <= pending;
         pend_full <= 1'b0;
      end else if (wr_valid && !pend_full) begin
         pending   <= wr_data;
         pend_full <= 1'b1;
      end
   end

   assign wr_ready = ~pend_full;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;

   localparam int DIV       = 8;
   localparam int BLANK_CYC = 2;
   localparam int FRAME     = 4 * DIV;

`ifdef LZ_BLANK_EN
   localparam bit LZ = 1'b1;
`else
   localparam bit LZ = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr_valid;
   logic [15:0] wr_data;
   logic        wr_ready;
   logic [3:0]  dp_en;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        frame_done;

   int          n_tests = 0;
   int          n_fail  = 0;

   logic [15:0] exp_q[$];
   logic [15:0] exp_active;

   always #5 clk = ~clk;

   seg_scan_ctrl #(
      .DIV       (DIV),
      .BLANK_CYC (BLANK_CYC)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_valid   (wr_valid),
      .wr_data    (wr_data),
      .wr_ready   (wr_ready),
      .dp_en      (dp_en),
      .an         (an),
      .seg        (seg),
      .dp         (dp),
      .frame_done (frame_done)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [6:0] ref_glyph(input logic [3:0] n);
      case (n)
         4'h0: return 7'b1000000;
         4'h1: return 7'b1111001;
         4'h2: return 7'b0100100;
         4'h3: return 7'b0110000;
         4'h4: return 7'b0011001;
         4'h5: return 7'b0010010;
         4'h6: return 7'b0000010;
         4'h7: return 7'b1111000;
         4'h8: return 7'b0000000;
         4'h9: return 7'b0010000;
         4'hA: return 7'b0001000;
         4'hB: return 7'b0000011;
         4'hC: return 7'b1000110;
         4'hD: return 7'b0100001;
         4'hE: return 7'b0000110;
         default: return 7'b0001110;
      endcase
   endfunction

   function automatic bit is_lz(input int i, input logic [15:0] act);
      logic [15:0] hi;
      hi = act >> (4 * i);
      return LZ && (i > 0) && (hi == 16'h0000);
   endfunction

   function automatic logic [3:0] exp_an(input int i, input logic [15:0] act, input logic [3:0] dpe);
      logic [3:0] a;
      a    = 4'hF;
      a[i] = 1'b0;
      if (is_lz(i, act) && !dpe[i]) a = 4'hF;
      return a;
   endfunction

   // Checks one frame sample by sample, starting right after a frame_done
   // sample (or reset release). Ends on the next frame_done sample, where
   // the scoreboard commits the oldest accepted value, if any.
   task automatic check_frame();
      for (int j = 1; j <= FRAME; j++) begin
         @(negedge clk);
         if (j == FRAME) begin
            chk("fd_pulse", {31'd0, frame_done}, 32'd1);
            chk("an_fd", {28'd0, an}, 32'hF);
            if (exp_q.size() > 0) exp_active = exp_q.pop_front();
         end else begin
            int i;
            int o;
            i = j / DIV;
            o = j % DIV;
            chk("fd_low", {31'd0, frame_done}, 32'd0);
            if (o >= BLANK_CYC) begin
               logic [3:0] ea;
               ea = exp_an(i, exp_active, dp_en);
               chk("an_lit", {28'd0, an}, {28'd0, ea});
               if (is_lz(i, exp_active)) begin
                  if (ea != 4'hF) chk("seg_lz", {25'd0, seg}, 32'h7F);
               end else begin
                  chk("seg", {25'd0, seg}, {25'd0, ref_glyph(exp_active[4*i +: 4])});
               end
               if (ea != 4'hF) chk("dp", {31'd0, dp}, {31'd0, ~dp_en[i]});
            end else begin
               chk("an_blank", {28'd0, an}, 32'hF);
            end
         end
      end
   endtask

   // Called on a negedge. Offers v until accepted, then pushes it to the
   // scoreboard (the accept happens on the following posedge).
   task automatic do_write(input logic [15:0] v);
      int n;
      n        = 0;
      wr_data  = v;
      wr_valid = 1'b1;
      while (!wr_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         chk("wr_timeout", 32'd0, 32'd1);
      end else begin
         exp_q.push_back(v);
      end
      @(negedge clk);
      wr_valid = 1'b0;
   endtask

   initial begin
      rst_n      = 1'b0;
      wr_valid   = 1'b0;
      wr_data    = 16'h0000;
      dp_en      = 4'b0000;
      exp_active = 16'h0000;

      // 1: reset state, then first frame shows 0000
      repeat (3) @(negedge clk);
      chk("rst_an", {28'd0, an}, 32'hF);
      chk("rst_seg", {25'd0, seg}, 32'h7F);
      chk("rst_dp", {31'd0, dp}, 32'd1);
      chk("rst_ready", {31'd0, wr_ready}, 32'd1);
      chk("rst_fd", {31'd0, frame_done}, 32'd0);
      rst_n = 1'b1;

      // 2: free run, anode order and frame_done period
      check_frame();
      dp_en = 4'b0101;
      check_frame();

      // 3: mid-frame write is held until the frame boundary
      fork
         check_frame();
         begin
            repeat (10) @(negedge clk);
            do_write(16'h1234);
         end
      join
      check_frame();

      // 4: second offer stalls until the first value is committed
      dp_en = 4'b1000;
      fork
         begin
            check_frame();
            check_frame();
         end
         begin
            repeat (5) @(negedge clk);
            do_write(16'h1111);
            chk("ready_full", {31'd0, wr_ready}, 32'd0);
            do_write(16'h2222);
         end
      join
      check_frame();

      // 5: leading zeros (blanked only with LZ_BLANK_EN)
      dp_en = 4'b0000;
      fork
         check_frame();
         begin
            repeat (5) @(negedge clk);
            do_write(16'h0005);
         end
      join
      check_frame();
      dp_en = 4'b0100;
      check_frame();
      dp_en = 4'b0000;
      do_write(16'hAB0D);
      exp_q.delete();
      repeat (2) @(negedge clk);

      // 6: reset mid-SHOW with a pending value
      // Realign on a frame boundary first.
      begin
         int n;
         n = 0;
         while (!frame_done && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
         end
         chk("fd_sync", {31'd0, frame_done}, 32'd1);
      end
      do_write(16'hABCD);
      repeat (3) @(negedge clk);
      chk("pre_rst_an", {28'd0, an}, 32'hE);
      #1 rst_n = 1'b0;
      #1;
      chk("async_an", {28'd0, an}, 32'hF);
      chk("async_seg", {25'd0, seg}, 32'h7F);
      chk("async_ready", {31'd0, wr_ready}, 32'd1);
      exp_q.delete();
      exp_active = 16'h0000;
      @(negedge clk);
      rst_n = 1'b1;
      check_frame();
      check_frame();
      chk("post_rst_ready", {31'd0, wr_ready}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
